// File: rtl/chimp_pkg.sv
// Shared constants and helpers for the channel impairment model.
package chimp_pkg;

   localparam logic [31:0] LFSR_MASK      = 32'h8020_0003;
   localparam logic [31:0] CH_SEED_STRIDE = 32'h9E37_79B9;

   // An all-zero Galois LFSR state never leaves zero, so map it to 1.
   function automatic logic [31:0] seed_fix(input logic [31:0] x);
      return (x == 32'h0) ? 32'h1 : x;
   endfunction

   // Clamp a sign-extended sum to the signed range of a width-bit sample.
   function automatic logic signed [31:0] sat_clip(input logic signed [31:0] sum,
                                                   input int unsigned      width);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = $signed((32'd1 << (width - 32'd1)) - 32'd1);
      lo = ~hi;
      if (sum > hi)      return hi;
      else if (sum < lo) return lo;
      else               return sum;
   endfunction

endpackage

// File: rtl/lfsr_galois32.sv
// 32-bit Galois LFSR with reseed; advances only when step is high.
module lfsr_galois32
   import chimp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] seed_init,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        step,
   output logic [31:0] state
);

   // Load has priority over step so a same-cycle reseed wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= seed_init;
      end else if (load) begin
         state <= load_val;
      end else if (step) begin
         state <= (state >> 1) ^ (state[0] ? LFSR_MASK : 32'h0);
      end
   end

endmodule

// File: rtl/channel_impairment.sv
// Adds bounded, re-seedable uniform noise to N_CH signed sample streams with
// saturating sums, through a fixed two-stage pipeline.
module channel_impairment
   import chimp_pkg::*;
#(
   parameter int unsigned DATA_W = 17,
   parameter int unsigned N_CH   = 2,
   parameter logic [31:0] SEED   = 32'hACE1_1234
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [DATA_W-2:0]        noise_amp,
   input  logic                     seed_load,
   input  logic [31:0]              seed_val,
   input  logic                     in_valid,
   input  logic [N_CH*DATA_W-1:0]   in_data,
   output logic                     out_valid,
   output logic [N_CH*DATA_W-1:0]   out_data,
   output logic [N_CH-1:0]          sat_flag
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned SUM_W  = DATA_W + 1;

   logic v1;

   // Valid qualification through both stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         v1        <= in_valid;
         out_valid <= v1;
      end
   end

   for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
      localparam logic [31:0] OFFSET = 32'(k) * CH_SEED_STRIDE;

      logic [31:0]              lfsr_q;
      logic signed [DATA_W-1:0] noise_src_c;
      logic signed [PROD_W-1:0] prod_c;
      logic signed [DATA_W-1:0] smp1;
      logic signed [PROD_W-1:0] prod1;
      logic signed [SUM_W-1:0]  noise_c;
      logic signed [SUM_W-1:0]  sum_c;
      logic signed [31:0]       sum_ext_c;
      logic signed [31:0]       clip_c;
      logic [DATA_W-1:0]        out_q;
      logic                     sat_q;

      lfsr_galois32 u_lfsr (
         .clk       (clk),
         .rst_n     (rst_n),
         .seed_init (seed_fix(SEED ^ OFFSET)),
         .load      (seed_load),
         .load_val  (seed_fix(seed_val ^ OFFSET)),
         .step      (in_valid),
         .state     (lfsr_q)
      );

      // Top LFSR bits as a signed uniform value scaled by the zero-extended amplitude.
      always_comb begin
         noise_src_c = DATA_W'(lfsr_q >> (32 - DATA_W));
         prod_c      = PROD_W'(noise_src_c) * PROD_W'($signed({1'b0, noise_amp}));
      end

      // Stage 1: capture sample and scaled noise; bypass zeroes the noise here.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            smp1  <= '0;
            prod1 <= '0;
         end else if (in_valid) begin
            smp1  <= in_data[k*DATA_W +: DATA_W];
            prod1 <= en ? prod_c : '0;
         end
      end

      // Noise in [-amp, amp), summed one bit wider, then clamped.
      always_comb begin
         noise_c   = SUM_W'(prod1 >>> (DATA_W - 1));
         sum_c     = SUM_W'(smp1) + noise_c;
         sum_ext_c = 32'(sum_c);
         clip_c    = sat_clip(sum_ext_c, DATA_W);
      end

      // Stage 2: register result; hold when nothing is arriving.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_q <= '0;
            sat_q <= 1'b0;
         end else if (v1) begin
            out_q <= DATA_W'(clip_c);
            sat_q <= (clip_c != sum_ext_c);
         end
      end

      assign out_data[k*DATA_W +: DATA_W] = out_q;
      assign sat_flag[k]                  = sat_q;
   end

endmodule

// File: tb/tb_channel_impairment.sv
// Directed bench for channel_impairment: vector table, hand-computed noise
// cases and a cycle-accurate reference model checked every clock.
module tb_channel_impairment;

   localparam int DW = 17;
   localparam int NC = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic [DW-2:0]     noise_amp;
   logic              seed_load;
   logic [31:0]       seed_val;
   logic              in_valid;
   logic [NC*DW-1:0]  in_data;
   logic              out_valid;
   logic [NC*DW-1:0]  out_data;
   logic [NC-1:0]     sat_flag;

   channel_impairment #(.DATA_W(DW), .N_CH(NC), .SEED(32'hACE1_1234)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .noise_amp (noise_amp),
      .seed_load (seed_load),
      .seed_val  (seed_val),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .sat_flag  (sat_flag)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   logic [31:0] m_lfsr [NC];
   logic        s1_v;
   int          s1_out [NC];
   logic        s1_sat [NC];
   logic        m_v;
   int          m_out  [NC];
   logic        m_sat  [NC];

   typedef struct {
      logic en;
      int   amp;
      int   in0;
      int   in1;
      int   exp0;
      int   exp1;
      logic sat0;
      logic sat1;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic [31:0] ref_seed(input logic [31:0] s, input int k);
      logic [31:0] x;
      x = s ^ (32'(k) * 32'h9E37_79B9);
      return (x == 32'h0) ? 32'h1 : x;
   endfunction

   function automatic int dut_out(input int k);
      logic signed [DW-1:0] v;
      v = out_data[k*DW +: DW];
      return int'(v);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NC; k++) begin
         m_lfsr[k] = ref_seed(32'hACE1_1234, k);
         s1_out[k] = 0;
         s1_sat[k] = 1'b0;
         m_out[k]  = 0;
         m_sat[k]  = 1'b0;
      end
      s1_v = 1'b0;
      m_v  = 1'b0;
   endtask

   // One clock: drive inputs, advance the model, check every output after the edge.
   task automatic cycle(input logic iv, input int d0, input int d1, input logic e,
                        input int amp, input logic sl, input logic [31:0] sv);
      longint r, n, s;
      int     d [NC];
      in_valid  = iv;
      en        = e;
      noise_amp = 16'(amp);
      seed_load = sl;
      seed_val  = sv;
      in_data   = {17'(d1), 17'(d0)};
      d[0] = d0;
      d[1] = d1;
      m_v = s1_v;
      if (s1_v) begin
         m_out = s1_out;
         m_sat = s1_sat;
      end
      s1_v = iv;
      for (int k = 0; k < NC; k++) begin
         if (iv) begin
            r = longint'($signed(m_lfsr[k][31:15]));
            n = e ? ((r * longint'(amp)) >>> 16) : 64'sd0;
            s = longint'(d[k]) + n;
            s1_sat[k] = (s > 65535) || (s < -65536);
            s1_out[k] = (s > 65535) ? 65535 : (s < -65536) ? -65536 : int'(s);
         end
         if (sl)      m_lfsr[k] = ref_seed(sv, k);
         else if (iv) m_lfsr[k] = ref_step(m_lfsr[k]);
      end
      @(posedge clk);
      #1;
      chk("model_out_valid", out_valid, m_v);
      for (int k = 0; k < NC; k++) begin
         chk($sformatf("model_out_data%0d", k), dut_out(k), m_out[k]);
         chk($sformatf("model_sat_flag%0d", k), sat_flag[k], m_sat[k]);
      end
   endtask

   task automatic idle(input int nc);
      for (int i = 0; i < nc; i++) cycle(1'b0, 0, 0, 1'b0, 0, 1'b0, 32'h0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, longint'(out_data), 0);
      chk({tag, "_sat_flag"}, longint'(sat_flag), 0);
   endtask

   // First accepted sample from the base seed, amp=65535, zero input.
   task automatic first_sample_check(input string tag);
      cycle(1'b1, 0, 0, 1'b1, 65535, 1'b0, 32'h0);
      idle(1);
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_ch0"}, dut_out(0), -42558);
      chk({tag, "_ch1"}, dut_out(1), 26027);
      chk({tag, "_sat"}, longint'(sat_flag), 0);
   endtask

   initial begin
      int     sat_cnt, nosat_cnt, pos_cnt, neg_cnt, max_abs, nsamp, idx, first_v;
      longint acc;
      logic   differs;
      int     ea [$];

      tbl[0] = '{1'b0, 65535,      0,      0,      0,      0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 65535,  65535, -65536,  65535, -65536, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 65535,     -1,      1,     -1,      1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 65535,  12345, -12345,  12345, -12345, 1'b0, 1'b0};
      tbl[4] = '{1'b1,     0, -65536,  65535, -65536,  65535, 1'b0, 1'b0};
      tbl[5] = '{1'b1,     0,    100,   -200,    100,   -200, 1'b0, 1'b0};
      tbl[6] = '{1'b1,     0,      0,      0,      0,      0, 1'b0, 1'b0};
      tbl[7] = '{1'b1,     0,     -1,  32767,     -1,  32767, 1'b0, 1'b0};

      rst_n = 1'b0; en = 1'b0; noise_amp = '0; seed_load = 1'b0; seed_val = '0;
      in_valid = 1'b0; in_data = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Hand case: strong noise pushes both channels past the rails.
      cycle(1'b1, -30000, 50000, 1'b1, 65535, 1'b0, 32'h0);
      chk("lat_not_early", out_valid, 0);
      idle(1);
      chk("hand_sat_valid", out_valid, 1);
      chk("hand_sat_ch0", dut_out(0), -65536);
      chk("hand_sat_ch1", dut_out(1), 65535);
      chk("hand_sat_flags", longint'(sat_flag), 3);

      // Reseed to the base seed reproduces the post-reset noise.
      cycle(1'b0, 0, 0, 1'b0, 0, 1'b1, 32'hACE1_1234);
      first_sample_check("hand_reseed");

      // Noise-free vector table, streamed back to back.
      for (int i = 0; i < 10; i++) begin
         if (i < 8) cycle(1'b1, tbl[i].in0, tbl[i].in1, tbl[i].en, tbl[i].amp, 1'b0, 32'h0);
         else       idle(1);
         if (i >= 1 && i <= 8) begin
            chk($sformatf("tbl%0d_valid", i-1), out_valid, 1);
            chk($sformatf("tbl%0d_ch0", i-1), dut_out(0), tbl[i-1].exp0);
            chk($sformatf("tbl%0d_ch1", i-1), dut_out(1), tbl[i-1].exp1);
            chk($sformatf("tbl%0d_sat", i-1), longint'(sat_flag), {tbl[i-1].sat1, tbl[i-1].sat0});
         end
      end
      chk("tbl_drain_valid", out_valid, 0);
      chk("tbl_hold_ch1", dut_out(1), 32767);

      // Bypass ramp.
      for (int i = 0; i < 100; i++) cycle(1'b1, i, -i, 1'b0, 65535, 1'b0, 32'h0);
      idle(2);
      chk("ramp_last_ch0", dut_out(0), 99);

      // Saturation at the rails.
      sat_cnt = 0; nosat_cnt = 0;
      for (int i = 0; i < 10000; i++) begin
         cycle(1'b1, (i % 2) ? -65536 : 65535, (i % 2) ? 65535 : -65536, 1'b1, 65535, 1'b0, 32'h0);
         if (out_valid) begin
            if (sat_flag[0]) sat_cnt++; else nosat_cnt++;
         end
      end
      idle(2);
      chk("sat_seen", sat_cnt > 0, 1);
      chk("nosat_seen", nosat_cnt > 0, 1);

      // Bound and mean with amp=1000.
      acc = 0; pos_cnt = 0; neg_cnt = 0; max_abs = 0; nsamp = 0;
      for (int i = 0; i < 20000; i++) begin
         cycle(1'b1, 0, 0, 1'b1, 1000, 1'b0, 32'h0);
         if (out_valid) begin
            for (int k = 0; k < NC; k++) begin
               idx = dut_out(k);
               acc += idx;
               nsamp++;
               if (idx > 0) pos_cnt++;
               if (idx < 0) neg_cnt++;
               if (idx < 0) idx = -idx;
               if (idx > max_abs) max_abs = idx;
            end
         end
      end
      idle(2);
      chk("bound_max_abs_ok", max_abs <= 1000, 1);
      chk("mean_ok", (acc <= 20 * longint'(nsamp)) && (acc >= -20 * longint'(nsamp)), 1);
      chk("both_signs", (pos_cnt > 0) && (neg_cnt > 0), 1);

      // Random mix: en/amp changes, gaps, seed_load coinciding with samples.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom), int'($signed(17'($urandom))), int'($signed(17'($urandom))),
               1'($urandom), int'($urandom_range(0, 65535)),
               ($urandom_range(0, 15) == 0), $urandom);
      end
      idle(2);

      // Repeatability: same seed, second run with gaps must match the first.
      cycle(1'b0, 0, 0, 1'b1, 1000, 1'b1, 32'h1234);
      for (int i = 0; i < 66; i++) begin
         if (i < 64) cycle(1'b1, 0, 0, 1'b1, 1000, 1'b0, 32'h0);
         else        idle(1);
         if (m_v && i >= 1) ea.push_back(m_out[0]);
      end
      cycle(1'b0, 0, 0, 1'b1, 1000, 1'b1, 32'h1234);
      idx = 0;
      for (int i = 0; i < 200 && idx < 64; i++) begin
         cycle((i % 3) != 2, 0, 0, 1'b1, 1000, 1'b0, 32'h0);
         if (out_valid && i >= 1 && idx < ea.size()) begin
            chk($sformatf("repeat_%0d", idx), dut_out(0), ea[idx]);
            idx++;
         end
      end
      chk("repeat_count", idx, 64);
      idle(2);

      // Zero seed must still produce varying noise.
      cycle(1'b0, 0, 0, 1'b1, 1000, 1'b1, 32'h0);
      differs = 1'b0; first_v = 0;
      for (int i = 0; i < 34; i++) begin
         cycle(1'b1, 0, 0, 1'b1, 1000, 1'b0, 32'h0);
         if (i == 1) first_v = dut_out(0);
         else if (i > 1 && dut_out(0) != first_v) differs = 1'b1;
      end
      idle(2);
      chk("seed0_nonconstant", differs, 1);

      // Mid-stream reset clears outputs immediately and restores base seeds.
      cycle(1'b1, 500, -500, 1'b1, 1000, 1'b0, 32'h0);
      cycle(1'b1, 500, -500, 1'b1, 1000, 1'b0, 32'h0);
      @(negedge clk);
      in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      first_sample_check("post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
